// File: rtl/apb_master_bridge_if.sv
// Bundle of the command stream, response stream and APB requester signals.
// The bridge uses the master modport; the environment drives the slave modport.
interface apb_master_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  logic        busy;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  rsp_ready,
    input  prdata, pready, pslverr,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pdata,
    output busy
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output rsp_ready,
    output prdata, pready, pslverr,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pdata,
    input  busy
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: one valid/ready command becomes one APB
// setup/access transfer, answered on a valid/ready response with optional timeout.
module apb_master_bridge #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic                pclk,
  input  logic                rst,
  apb_master_bridge_if.master bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Counter value seen on the last permitted wait cycle before abort.
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

  logic [1:0]       state_q,     state_d;
  logic [CNT_W-1:0] wait_cnt_q,  wait_cnt_d;
  logic             psel_q,      psel_d;
  logic             penable_q,   penable_d;
  logic             pwrite_q,    pwrite_d;
  logic [31:0]      paddr_q,     paddr_d;
  logic [31:0]      pdata_q,     pdata_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q,   rsp_err_d;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pdata_d     = pdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          pwrite_d = bus.req_write;
          paddr_d  = bus.req_addr;
          pdata_d  = bus.req_wdata;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (bus.pready) begin
          rsp_rdata_d = pwrite_q ? 32'd0 : bus.prdata;
          rsp_err_d   = bus.pslverr;
          wait_cnt_d  = '0;
          state_d     = ST_RESP;
        end else if (TIMEOUT_EN && (wait_cnt_q == WAIT_LAST)) begin
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b1;
          wait_cnt_d  = '0;
          state_d     = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Bus strobes are registered images of the next state.
    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 32'd0;
      pdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pdata_q     <= pdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pdata     = pdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed vector table, random transfers against
// a transfer-level model, plus reset-abort and no-timeout sequences.
module tb_apb_master_bridge;

  localparam int TO = 4;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  apb_master_bridge_if bus ();
  apb_master_bridge_if bus0 ();

  apb_master_bridge #(.TIMEOUT(TO), .CNT_W(3)) u_dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  apb_master_bridge #(.TIMEOUT(0), .CNT_W(9)) u_dut0 (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus0)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    logic        slverr;
    int          rsp_delay;
    int          exp_acc;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Transfer-level outcome: slave answers after 'waits' low-pready cycles
  // unless the timeout budget of TO access cycles runs out first.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit   timed_out = (v.waits >= TO);
    r.exp_acc   = timed_out ? TO : v.waits + 1;
    r.exp_err   = timed_out ? 1'b1 : v.slverr;
    r.exp_rdata = (timed_out || v.write) ? 32'd0 : v.prdata;
    return r;
  endfunction

  // Starts and ends on a falling edge with the bridge idle.
  task automatic run_vec(input vec_t v, input string tag);
    int guard, n_setup, n_acc, lat;
    bit got, addr_ok, rsp_ok;
    bus.req_valid = 1'b1;
    bus.req_write = v.write;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.rsp_ready = 1'b0;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge pclk);
      guard++;
    end
    chk({tag, " accept"}, 32'(bus.req_ready), 32'd1);
    @(negedge pclk);
    bus.req_valid = 1'b0;
    n_setup = 0; n_acc = 0; lat = 1; got = 0; addr_ok = 1;
    while (!got && lat < 100) begin
      if (bus.rsp_valid) begin
        got = 1;
      end else begin
        if (bus.psel && !bus.penable) n_setup++;
        if (bus.psel && (bus.paddr !== v.addr || bus.pdata !== v.wdata || bus.pwrite !== v.write))
          addr_ok = 0;
        if (bus.psel && bus.penable) begin
          bus.pready  = (n_acc == v.waits);
          bus.prdata  = bus.pready ? v.prdata : $urandom;
          bus.pslverr = bus.pready ? v.slverr : 1'($urandom);
          n_acc++;
        end else begin
          bus.pready  = 1'($urandom);
          bus.prdata  = $urandom;
          bus.pslverr = 1'($urandom);
        end
        @(negedge pclk);
        lat++;
      end
    end
    chk({tag, " rsp_seen"}, 32'(got), 32'd1);
    if (!got) return;
    chk({tag, " setup_cycles"}, 32'(n_setup), 32'd1);
    chk({tag, " access_cycles"}, 32'(n_acc), 32'(v.exp_acc));
    chk({tag, " rsp_latency"}, 32'(lat), 32'(v.exp_acc + 2));
    chk({tag, " addr_stable"}, 32'(addr_ok), 32'd1);
    chk({tag, " rsp_rdata"}, bus.rsp_rdata, v.exp_rdata);
    chk({tag, " rsp_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
    chk({tag, " resp_psel"}, {bus.psel, bus.penable, bus.req_ready, bus.busy}, 4'b0001);
    rsp_ok = 1;
    for (int d = 0; d < v.rsp_delay; d++) begin
      bus.req_valid = 1'($urandom);
      bus.req_addr  = $urandom;
      bus.pready    = 1'($urandom);
      bus.prdata    = $urandom;
      bus.pslverr   = 1'($urandom);
      @(negedge pclk);
      if (!bus.rsp_valid || bus.rsp_rdata !== v.exp_rdata || bus.rsp_err !== v.exp_err ||
          bus.psel || bus.penable || bus.req_ready || bus.paddr !== v.addr)
        rsp_ok = 0;
    end
    chk({tag, " rsp_hold"}, 32'(rsp_ok), 32'd1);
    bus.rsp_ready = 1'b1;
    @(negedge pclk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    chk({tag, " rsp_done"}, {bus.rsp_valid, bus.req_ready, bus.psel}, 3'b010);
  endtask

  vec_t vecs[7];
  vec_t rv;
  bit   flag;
  int   guard;

  initial begin
    // Directed table: expectations written out by hand.
    vecs[0] = '{1'b1, 32'h8004_0004, 32'h0000_00A5, 32'h1111_1111, 0, 1'b0, 0, 1, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h8004_0008, 32'h0,         32'h0000_1234, 3, 1'b0, 0, 4, 1'b0, 32'h1234};
    vecs[2] = '{1'b0, 32'h8004_000C, 32'h0,         32'hDEAD_BEEF, 0, 1'b1, 1, 1, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 32'h8004_0010, 32'h0,         32'h7777_7777, 99, 1'b0, 0, 4, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 32'h8004_0014, 32'h0,         32'h0000_55AA, 0, 1'b0, 10, 1, 1'b0, 32'h55AA};
    vecs[5] = '{1'b1, 32'h8004_0018, 32'hCAFE_0001, 32'h2222_2222, 3, 1'b1, 2, 4, 1'b1, 32'h0};
    vecs[6] = '{1'b1, 32'h8004_001C, 32'h1234_5678, 32'h0,         4, 1'b0, 0, 4, 1'b1, 32'h0};

    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.rsp_ready = 0; bus.prdata = 0; bus.pready = 0; bus.pslverr = 0;
    bus0.req_valid = 0; bus0.req_write = 0; bus0.req_addr = 0; bus0.req_wdata = 0;
    bus0.rsp_ready = 0; bus0.prdata = 0; bus0.pready = 0; bus0.pslverr = 0;

    repeat (3) @(posedge pclk);
    @(negedge pclk);
    rst = 1'b0;
    chk("reset ctrl", {bus.req_ready, bus.busy, bus.psel, bus.penable, bus.pwrite,
                       bus.rsp_valid, bus.rsp_err}, 7'b1000000);
    chk("reset paddr", bus.paddr, 32'h0);
    chk("reset pdata", bus.pdata, 32'h0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'h0);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 150; i++) begin
      rv.write     = 1'($urandom);
      rv.addr      = $urandom;
      rv.wdata     = $urandom;
      rv.prdata    = $urandom;
      rv.waits     = int'($urandom_range(0, 6));
      rv.slverr    = ($urandom_range(0, 3) == 0);
      rv.rsp_delay = int'($urandom_range(0, 3));
      rv = model(rv);
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    // Reset during a waited read: the command must vanish without a response.
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h8004_0020;
    bus.pready = 1'b0;
    @(negedge pclk);
    bus.req_valid = 1'b0;
    @(negedge pclk);
    chk("rst_mid in_access", {bus.psel, bus.penable}, 2'b11);
    @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    chk("rst_mid after", {bus.psel, bus.penable, bus.rsp_valid, bus.req_ready, bus.busy}, 5'b00010);
    rst = 1'b0;
    flag = 1;
    for (int i = 0; i < 12; i++) begin
      bus.pready = 1'($urandom);
      @(negedge pclk);
      if (bus.rsp_valid || bus.psel || !bus.req_ready) flag = 0;
    end
    chk("rst_mid no_replay", 32'(flag), 32'd1);

    // TIMEOUT=0 instance: a slave stalling 1000 cycles never triggers an abort.
    bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_addr = 32'h8004_0040;
    bus0.pready = 1'b0;
    @(negedge pclk);
    bus0.req_valid = 1'b0;
    guard = 0;
    while (!(bus0.psel && bus0.penable) && guard < 10) begin
      @(negedge pclk);
      guard++;
    end
    chk("noto enter_access", {bus0.psel, bus0.penable}, 2'b11);
    flag = 1;
    for (int i = 0; i < 1000; i++) begin
      if (!(bus0.psel && bus0.penable) || bus0.rsp_valid) flag = 0;
      @(negedge pclk);
    end
    chk("noto still_waiting", 32'(flag), 32'd1);
    bus0.pready = 1'b1; bus0.prdata = 32'hCAFE_F00D; bus0.pslverr = 1'b0;
    @(negedge pclk);
    bus0.pready = 1'b0;
    chk("noto rsp_valid", {bus0.rsp_valid, bus0.rsp_err, bus0.psel}, 3'b100);
    chk("noto rsp_rdata", bus0.rsp_rdata, 32'hCAFE_F00D);
    bus0.rsp_ready = 1'b1;
    @(negedge pclk);
    bus0.rsp_ready = 1'b0;
    chk("noto done", {bus0.rsp_valid, bus0.req_ready}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
